// File: rtl/jpeg_idct_pkg.sv
// ----------------------------------------------------------------------------
// jpeg_idct_pkg
//   Constants shared by the IDCT row serialiser and the transpose buffer.
//   A coefficient index is {lane[1:0], beat[3:0]}: the lane picks the buffer
//   bank and the beat picks the address inside that bank.
// ----------------------------------------------------------------------------
package jpeg_idct_pkg;

  localparam int JPEG_IDX_W  = 6;
  localparam int JPEG_BEAT_W = 4;
  localparam int JPEG_LANES  = 4;
  localparam int JPEG_LANE_W = JPEG_IDX_W - JPEG_BEAT_W;

  localparam logic [JPEG_IDX_W-1:0] LAST_IDX = 6'd63;

  // Bank/address tag for one coefficient word.
  function automatic logic [JPEG_IDX_W-1:0] jpeg_coef_idx(
    input logic [JPEG_LANE_W-1:0] lane,
    input logic [JPEG_BEAT_W-1:0] beat
  );
    return {lane, beat};
  endfunction

endpackage

// File: rtl/jpeg_idct_row_serialiser_if.sv
// ----------------------------------------------------------------------------
// jpeg_idct_row_serialiser_if
//   Bundles the serialiser's two handshake buses:
//     inport  : 4-lane row-pass beat (valid/accept, 4 x DATA_W data, 4b beat idx)
//     outport : 1 x DATA_W word tagged with a 6b coefficient idx (valid/accept)
//   slave  - the serialiser (consumes inport, produces outport)
//   master - the environment (row datapath upstream, transpose buffer downstream)
// ----------------------------------------------------------------------------
interface jpeg_idct_row_serialiser_if #(
  parameter int DATA_W = 32
);

  logic                                  inport_valid_i;
  logic [DATA_W-1:0]                     inport_data0_i;
  logic [DATA_W-1:0]                     inport_data1_i;
  logic [DATA_W-1:0]                     inport_data2_i;
  logic [DATA_W-1:0]                     inport_data3_i;
  logic [jpeg_idct_pkg::JPEG_BEAT_W-1:0] inport_idx_i;
  logic                                  inport_accept_o;

  logic                                  outport_valid_o;
  logic [DATA_W-1:0]                     outport_data_o;
  logic [jpeg_idct_pkg::JPEG_IDX_W-1:0]  outport_idx_o;
  logic                                  outport_accept_i;

  modport slave (
    input  inport_valid_i, inport_data0_i, inport_data1_i, inport_data2_i,
           inport_data3_i, inport_idx_i, outport_accept_i,
    output inport_accept_o, outport_valid_o, outport_data_o, outport_idx_o
  );

  modport master (
    output inport_valid_i, inport_data0_i, inport_data1_i, inport_data2_i,
           inport_data3_i, inport_idx_i, outport_accept_i,
    input  inport_accept_o, outport_valid_o, outport_data_o, outport_idx_o
  );

endinterface

// File: rtl/jpeg_idct_beat_fifo.sv
// ----------------------------------------------------------------------------
// jpeg_idct_beat_fifo
//   Small synchronous FIFO holding whole row-pass beats.
//   Ports:
//     clk_i, rst_ni  clock / asynchronous active-low reset
//     clr_i          synchronous flush (pointers and count to zero)
//     push_i, din_i  write one entry (ignored when full)
//     pop_i, dout_o  drop the head entry (ignored when empty); dout_o is head
//     full_o,empty_o occupancy flags, both from registered count only
// ----------------------------------------------------------------------------
module jpeg_idct_beat_fifo #(
  parameter int WIDTH = 132,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observed once
  // the count says it was written, so resetting it would only cost flops.
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) r_mem[r_wr_ptr] <= din_i;
  end

  assign dout_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/jpeg_idct_row_serialiser.sv
// ----------------------------------------------------------------------------
// jpeg_idct_row_serialiser
//   Write-side feeder for the IDCT transpose buffer. Buffers 4-lane row-pass
//   beats and replays each as four 1-word transfers tagged {lane, beat}, in
//   lane order 0..3, so beat b yields idx b, 16+b, 32+b, 48+b.
//   Ports:
//     clk_i, rst_ni  clock / asynchronous active-low reset
//     img_start_i    synchronous clear of all state, highest priority
//     bus (slave)    inport beat handshake and outport word handshake
//     block_done_o   registered pulse after the idx 63 word transfers
//     seq_err_o      sticky flag: an accepted beat was not the expected one
// ----------------------------------------------------------------------------
module jpeg_idct_row_serialiser
  import jpeg_idct_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        img_start_i,
  jpeg_idct_row_serialiser_if.slave   bus,
  output logic                        block_done_o,
  output logic                        seq_err_o
);

  localparam int ENTRY_W = JPEG_LANES * DATA_W + JPEG_BEAT_W;

  logic [ENTRY_W-1:0]     w_entry;
  logic [ENTRY_W-1:0]     w_head;
  logic [DATA_W-1:0]      w_lanes [JPEG_LANES];
  logic [JPEG_BEAT_W-1:0] w_head_beat;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_xfer;
  logic                   w_pop;

  logic [JPEG_LANE_W-1:0] r_lane;
  logic [JPEG_BEAT_W-1:0] r_exp_beat;
  logic                   r_seq_err;
  logic                   r_done;

  // Entry layout: {lane3, lane2, lane1, lane0, beat}.
  assign w_entry = {bus.inport_data3_i, bus.inport_data2_i,
                    bus.inport_data1_i, bus.inport_data0_i, bus.inport_idx_i};

  // Accept depends only on registered occupancy, so it never sees the
  // downstream accept combinationally; a pop from full frees space next cycle.
  assign bus.inport_accept_o = !w_full && !img_start_i;
  assign w_push              = bus.inport_valid_i && bus.inport_accept_o;

  assign w_xfer = bus.outport_valid_o && bus.outport_accept_i && !img_start_i;
  assign w_pop  = w_xfer && (r_lane == JPEG_LANE_W'(JPEG_LANES - 1));

  jpeg_idct_beat_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (img_start_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_entry),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_beat = w_head[JPEG_BEAT_W-1:0];

  for (genvar k = 0; k < JPEG_LANES; k++) begin : g_lane
    assign w_lanes[k] = w_head[JPEG_BEAT_W + k*DATA_W +: DATA_W];
  end

  // Data and idx are forced to zero when idle so the bus never shows stale
  // (possibly uninitialised) buffer contents.
  assign bus.outport_valid_o = !w_empty;
  assign bus.outport_data_o  = bus.outport_valid_o ? w_lanes[r_lane] : '0;
  assign bus.outport_idx_o   = bus.outport_valid_o ? jpeg_coef_idx(r_lane, w_head_beat) : '0;

  // Lane counter: advances on every transfer, wraps to 0 as the head pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lane <= '0;
    end else if (img_start_i) begin
      r_lane <= '0;
    end else if (w_xfer) begin
      r_lane <= r_lane + 1'b1;
    end
  end

  // Sequence checker: flags a mismatch but resyncs to whatever arrived, so
  // one dropped beat produces one error instead of a cascade.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exp_beat <= '0;
      r_seq_err  <= 1'b0;
    end else if (img_start_i) begin
      r_exp_beat <= '0;
      r_seq_err  <= 1'b0;
    end else if (w_push) begin
      if (bus.inport_idx_i != r_exp_beat) r_seq_err <= 1'b1;
      r_exp_beat <= bus.inport_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= 1'b0;
    end else if (img_start_i) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && (bus.outport_idx_o == LAST_IDX);
    end
  end

  assign block_done_o = r_done;
  assign seq_err_o    = r_seq_err;

endmodule

// File: tb/tb_jpeg_idct_row_serialiser.sv
// ----------------------------------------------------------------------------
// tb_jpeg_idct_row_serialiser
//   Scoreboard bench. An input monitor turns every accepted beat into the four
//   words it must produce (idx = lane*16 + beat, data = that lane) and pushes
//   them into a queue; an output monitor pops and compares on each transfer.
//   The model also tracks buffered beats, expected beat number and the sticky
//   sequence error from the behavioural rules alone.
// ----------------------------------------------------------------------------
module tb_jpeg_idct_row_serialiser;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [5:0]    idx;
    logic [DW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic img_start = 1'b0;
  logic block_done;
  logic seq_err;

  always #5 clk = ~clk;

  jpeg_idct_row_serialiser_if #(.DATA_W(DW)) bus ();

  jpeg_idct_row_serialiser #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .img_start_i  (img_start),
    .bus          (bus),
    .block_done_o (block_done),
    .seq_err_o    (seq_err)
  );

  // Scoreboard and model state.
  word_t      sb_q[$];
  int         n_vec = 0;
  int         n_miss = 0;
  int         pushed = 0;       // beats accepted (input monitor)
  int         popped = 0;       // beats fully emitted (output monitor)
  int         pend = 0;         // words queued this cycle, not yet in the DUT
  logic [3:0] m_exp = 4'd0;
  logic       m_err = 1'b0;
  logic       exp_done = 1'b0;
  int         done_cnt = 0;
  int         xfer_cnt = 0;
  int         last_done_xfer = 0;
  int         done_gap = 0;
  int         full_seen = 0;
  int         ready_n = 0;
  int         acc_mode = 0;     // 0: always accept, 1: one in three, 2: random
  int         cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream accept pattern.
  initial begin
    bus.outport_accept_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (acc_mode)
        0:       bus.outport_accept_i = 1'b1;
        1:       bus.outport_accept_i = (cyc % 3 == 0);
        default: bus.outport_accept_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Input monitor: model of the accept rule, sequence checker and expected words.
  always @(negedge clk) begin
    pend = 0;
    if (!rst_ni) begin
      sb_q.delete();
      pushed = popped;
      m_exp  = 4'd0;
      m_err  = 1'b0;
    end else if (img_start) begin
      check("accept_during_start", bus.inport_accept_o, 1'b0);
      check("seq_err", seq_err, m_err);
      sb_q.delete();
      pushed = popped;
      m_exp  = 4'd0;
      m_err  = 1'b0;
    end else begin
      check("inport_accept", bus.inport_accept_o, (pushed - popped) < DEPTH);
      check("seq_err", seq_err, m_err);
      if (!bus.inport_accept_o) full_seen++;
      if (bus.inport_valid_i && bus.inport_accept_o) begin
        if (bus.inport_idx_i != m_exp) m_err = 1'b1;
        m_exp = bus.inport_idx_i + 4'd1;
        sb_q.push_back('{idx: {2'd0, bus.inport_idx_i}, data: bus.inport_data0_i});
        sb_q.push_back('{idx: {2'd1, bus.inport_idx_i}, data: bus.inport_data1_i});
        sb_q.push_back('{idx: {2'd2, bus.inport_idx_i}, data: bus.inport_data2_i});
        sb_q.push_back('{idx: {2'd3, bus.inport_idx_i}, data: bus.inport_data3_i});
        pushed++;
        pend = 4;
      end
    end
  end

  // Output monitor: compares the presented word with the scoreboard head.
  always @(negedge clk) begin
    word_t w;
    #1;
    if (!rst_ni || img_start) begin
      exp_done = 1'b0;
    end else begin
      check("block_done", block_done, exp_done);
      if (block_done) begin
        done_cnt++;
        done_gap       = xfer_cnt - last_done_xfer;
        last_done_xfer = xfer_cnt;
      end
      ready_n = sb_q.size() - pend;
      check("outport_valid", bus.outport_valid_o, ready_n > 0);
      exp_done = 1'b0;
      if (bus.outport_valid_o && ready_n > 0) begin
        w = sb_q[0];
        check("outport_idx", bus.outport_idx_o, w.idx);
        check("outport_data", bus.outport_data_o, w.data);
        if (bus.outport_accept_i) begin
          void'(sb_q.pop_front());
          xfer_cnt++;
          if (w.idx == 6'd63) exp_done = 1'b1;
          if (w.idx[5:4] == 2'd3) popped++;
        end
      end else if (!bus.outport_valid_o) begin
        check("idle_data", bus.outport_data_o, '0);
        check("idle_idx", bus.outport_idx_o, '0);
      end
    end
  end

  // Drives one beat and holds it until accepted (bounded).
  task automatic send_beat(input logic [3:0] b, input bit tagged_lanes);
    bit got;
    int waited;
    bus.inport_valid_i = 1'b1;
    bus.inport_idx_i   = b;
    bus.inport_data0_i = tagged_lanes ? 32'h0000 + 32'(b) : $urandom;
    bus.inport_data1_i = tagged_lanes ? 32'h0100 + 32'(b) : $urandom;
    bus.inport_data2_i = tagged_lanes ? 32'h0200 + 32'(b) : $urandom;
    bus.inport_data3_i = tagged_lanes ? 32'h0300 + 32'(b) : $urandom;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 500) begin
      @(negedge clk);
      got = bus.inport_accept_o;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.inport_valid_i = 1'b0;
    if (!got) check("send_timeout", got, 1'b1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || bus.outport_valid_o) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 2000) check("drain_timeout", sb_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int d0, x0, f0;
    bit found;
    bus.inport_valid_i = 1'b0;
    bus.inport_idx_i   = '0;
    bus.inport_data0_i = '0;
    bus.inport_data1_i = '0;
    bus.inport_data2_i = '0;
    bus.inport_data3_i = '0;

    // Reset state.
    #3;
    check("rst_valid", bus.outport_valid_o, 1'b0);
    check("rst_data", bus.outport_data_o, '0);
    check("rst_idx", bus.outport_idx_o, '0);
    check("rst_accept", bus.inport_accept_o, 1'b1);
    check("rst_seq_err", seq_err, 1'b0);
    check("rst_done", block_done, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // 1: one block, tagged lanes, full-rate downstream.
    acc_mode = 0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    for (int b = 0; b < 16; b++) send_beat(4'(b), 1'b1);
    drain();
    check("s1_words", xfer_cnt - x0, 64);
    check("s1_done_pulses", done_cnt - d0, 1);
    check("s1_seq_err", seq_err, 1'b0);

    // 2: slow downstream, FIFO must fill and back-pressure.
    acc_mode = 1;
    x0 = xfer_cnt;
    f0 = full_seen;
    for (int b = 0; b < 16; b++) send_beat(4'(b), 1'b0);
    drain();
    check("s2_words", xfer_cnt - x0, 64);
    check("s2_backpressure_seen", full_seen > f0, 1'b1);

    // 3: skipped beat 2.
    acc_mode = 2;
    send_beat(4'd0, 1'b0);
    send_beat(4'd1, 1'b0);
    check("s3_no_err_yet", seq_err, 1'b0);
    send_beat(4'd3, 1'b0);
    check("s3_err_after_3", seq_err, 1'b1);
    send_beat(4'd4, 1'b0);
    drain();
    check("s3_err_sticky", seq_err, 1'b1);

    // 4: image restart while beat 5 is on lane 2.
    acc_mode = 0;
    for (int b = 0; b < 6; b++) send_beat(4'(b), 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.outport_valid_o && bus.outport_idx_o == 6'd37) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("s4_reached_idx37", found, 1'b1);
    img_start = 1'b1;
    @(posedge clk);
    #1;
    img_start = 1'b0;
    check("s4_valid_cleared", bus.outport_valid_o, 1'b0);
    check("s4_err_cleared", seq_err, 1'b0);
    send_beat(4'd0, 1'b0);
    drain();
    check("s4_restart_no_err", seq_err, 1'b0);

    // 5: asynchronous reset mid-block.
    for (int b = 1; b < 7; b++) send_beat(4'(b), 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("s5_async_valid", bus.outport_valid_o, 1'b0);
    check("s5_async_accept", bus.inport_accept_o, 1'b1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // 6: two back-to-back blocks.
    d0 = done_cnt;
    x0 = xfer_cnt;
    for (int n = 0; n < 2; n++)
      for (int b = 0; b < 16; b++) send_beat(4'(b), 1'b0);
    drain();
    check("s6_words", xfer_cnt - x0, 128);
    check("s6_done_pulses", done_cnt - d0, 2);
    check("s6_done_spacing", done_gap, 64);
    check("s6_seq_err", seq_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
